rcv: RTL and testbench

Serial line receiver, the receiving end of the 8N1 link driven by the team's `xmt` transmitter. It samples an idle-high asynchronous line, detects the start bit, and recovers 8 data bits LSB first plus one stop bit at a parameterised bit duration (default 2 kbaud at 50 MHz). Each received byte is presented in a holding register with a full/read handshake, together with sticky framing and overrun flags. It sits beside `xmt` in the serial back-end and feeds the host-side command logic.

---
 rtl/rcv.sv | 214 +++++++++++++++++++++
 tb/tb_rcv.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rcv.sv
// rcv: 8N1 serial line receiver.
// Samples an idle-high asynchronous line through a two-flop synchroniser,
// times the start/data/stop bits with a down-counter, and presents each
// received byte in a holding register with a full/read handshake plus
// sticky framing-error and overrun flags.
module rcv #(
  parameter int BIT_CLOCKS  = 25000,          // clock cycles per bit
  parameter int HALF_CLOCKS = BIT_CLOCKS / 2  // start edge to start-bit sample
) (
  input  logic       clk,
  input  logic       reset,          // asynchronous, active low
  input  logic       serial_in,
  input  logic       read,
  output logic       full,
  output logic [7:0] parallel_out,
  output logic       framing_error,
  output logic       overrun
);

  localparam logic [31:0] BIT_LOAD  = 32'(BIT_CLOCKS);
  localparam logic [31:0] HALF_LOAD = 32'(HALF_CLOCKS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  sync_reg;
  logic        rx_s;
  logic [31:0] count_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic        full_reg, full_next;
  logic [7:0]  data_reg, data_next;
  logic        fe_reg, fe_next;
  logic        ovr_reg, ovr_next;

  // FSM control strobes
  logic count_zero;
  logic load_half;
  logic load_bit;
  logic count_dec;
  logic clr_bits;
  logic shift_en;
  logic byte_ok;
  logic byte_bad;

  assign rx_s       = sync_reg[1];
  assign count_zero = (count_reg == 32'd0);

  // Two-flop synchroniser; idle-high so reset loads ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], serial_in};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: bit-time decisions only on the cycle the counter hits zero.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (count_zero) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (count_zero && (bit_cnt_reg == 3'd7)) state_next = STOP;
      end
      STOP: begin
        if (count_zero) state_next = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        // A held-low line stays here so it only ever reports one framing error.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: datapath strobes decoded from state, line and counter.
  always_comb begin
    load_half = 1'b0;
    load_bit  = 1'b0;
    count_dec = 1'b0;
    clr_bits  = 1'b0;
    shift_en  = 1'b0;
    byte_ok   = 1'b0;
    byte_bad  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) load_half = 1'b1;
      end
      START: begin
        if (!count_zero) begin
          count_dec = 1'b1;
        end else if (!rx_s) begin
          load_bit = 1'b1;
          clr_bits = 1'b1;
        end
      end
      DATA: begin
        if (!count_zero) begin
          count_dec = 1'b1;
        end else begin
          shift_en = 1'b1;
          load_bit = 1'b1;
        end
      end
      STOP: begin
        if (!count_zero) begin
          count_dec = 1'b1;
        end else if (rx_s) begin
          byte_ok = 1'b1;
        end else begin
          byte_bad = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bit-time down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= 32'd0;
    end else if (load_half) begin
      count_reg <= HALF_LOAD;
    end else if (load_bit) begin
      count_reg <= BIT_LOAD;
    end else if (count_dec) begin
      count_reg <= count_reg - 32'd1;
    end
  end

  // Bit counter: wraps from 7 on the last data bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_reg <= 3'd0;
    end else if (clr_bits) begin
      bit_cnt_reg <= 3'd0;
    end else if (shift_en) begin
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
    end
  end

  // Shift register filled from the MSB side so the first (LSB) bit ends at bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= 8'h00;
    end else if (shift_en) begin
      shift_reg <= {rx_s, shift_reg[7:1]};
    end
  end

  // Holding register and flags: read clears first, a same-cycle completion overrides.
  always_comb begin
    full_next = full_reg;
    data_next = data_reg;
    fe_next   = fe_reg;
    ovr_next  = ovr_reg;
    if (read) begin
      full_next = 1'b0;
      fe_next   = 1'b0;
      ovr_next  = 1'b0;
    end
    if (byte_ok) begin
      data_next = shift_reg;
      full_next = 1'b1;
      // An unread byte being overwritten is an overrun unless it is being taken now.
      if (full_reg && !read) ovr_next = 1'b1;
    end
    if (byte_bad) begin
      fe_next = 1'b1;
    end
  end

  // Holding register and flag storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_reg <= 1'b0;
      data_reg <= 8'h00;
      fe_reg   <= 1'b0;
      ovr_reg  <= 1'b0;
    end else begin
      full_reg <= full_next;
      data_reg <= data_next;
      fe_reg   <= fe_next;
      ovr_reg  <= ovr_next;
    end
  end

  assign full          = full_reg;
  assign parallel_out  = data_reg;
  assign framing_error = fe_reg;
  assign overrun       = ovr_reg;

endmodule

// File: tb/tb_rcv.sv
// tb_rcv: self-checking bench for the rcv serial receiver.
// The bench plays the transmitting end of the link and keeps an event-level
// model of the holding register and flags.
module tb_rcv;

  localparam int BIT    = 16;
  localparam int HALF   = BIT / 2;
  // The link transmitter uses the same load-then-count-to-zero timer, so each
  // line bit lasts BIT+1 cycles, matching the receiver's sample spacing.
  localparam int P      = BIT + 1;
  localparam int FRAME  = 10 * P;
  // Start drive after edge 0: rx_s low seen at edge 3, start sample HALF+1
  // later, then nine more samples BIT+1 apart; the last is the stop sample.
  localparam int DONE_C = 3 + HALF + 1 + 9 * (BIT + 1);

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic       read;
  logic       full;
  logic [7:0] parallel_out;
  logic       framing_error;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int fe_rise = 0;
  logic fe_prev = 1'b0;

  // model of the receiver's visible state
  logic       m_full = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_fe   = 1'b0;
  logic       m_ovr  = 1'b0;

  rcv #(.BIT_CLOCKS(BIT), .HALF_CLOCKS(HALF)) dut (
    .clk(clk),
    .reset(reset),
    .serial_in(serial_in),
    .read(read),
    .full(full),
    .parallel_out(parallel_out),
    .framing_error(framing_error),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count framing-error assertions
  always @(negedge clk) begin
    if (framing_error && !fe_prev) fe_rise++;
    fe_prev = framing_error;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_full"}, 32'(full), 32'(m_full));
    check_val({tag, "_data"}, 32'(parallel_out), 32'(m_data));
    check_val({tag, "_fe"}, 32'(framing_error), 32'(m_fe));
    check_val({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  // Model update for one clock edge; read holds the value the DUT saw.
  task automatic apply_edge(input bit done_ok, input bit done_bad, input logic [7:0] b);
    logic rd;
    logic was_full;
    rd = read;
    was_full = m_full;
    if (rd) begin
      m_full = 1'b0;
      m_fe   = 1'b0;
      m_ovr  = 1'b0;
    end
    if (done_ok) begin
      m_data = b;
      m_full = 1'b1;
      if (was_full && !rd) m_ovr = 1'b1;
    end
    if (done_bad) m_fe = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input logic line);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      apply_edge(1'b0, 1'b0, 8'h00);
      #1;
      serial_in = line;
      read = 1'b0;
    end
  endtask

  task automatic pulse_read(input string tag);
    @(posedge clk);
    apply_edge(1'b0, 1'b0, 8'h00);
    #1 read = 1'b1;
    @(posedge clk);
    apply_edge(1'b0, 1'b0, 8'h00);
    #1 read = 1'b0;
    check_val({tag, "_rdclr"}, 32'(full), 32'(m_full));
  endtask

  // One 8N1 frame; read_at / abort_at are cycle indices (-1 = none).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int read_at, input int abort_at);
    int k;
    for (int c = 0; c < FRAME; c++) begin
      @(posedge clk);
      apply_edge((c == DONE_C) && stop_bit, (c == DONE_C) && !stop_bit, b);
      if (c == abort_at) begin
        reset = 1'b0;
        #1;
        m_full = 1'b0; m_data = 8'h00; m_fe = 1'b0; m_ovr = 1'b0;
        check_outputs("midrst");
        serial_in = 1'b1;
        read = 1'b0;
        return;
      end
      #1;
      k = c / P;
      if (k == 0)      serial_in = 1'b0;
      else if (k <= 8) serial_in = b[k-1];
      else             serial_in = stop_bit;
      read = (c == read_at);
    end
  endtask

  initial begin
    int r0;
    logic [7:0] b;
    logic st;
    int mode;
    reset = 1'b0;
    serial_in = 1'b1;
    read = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs("reset");
    reset = 1'b1;
    idle_cycles(10, 1'b1);

    // basic byte
    send_frame(8'hA5, 1'b1, -1, -1);
    check_outputs("basic");
    pulse_read("basic");

    // back-to-back stream, each byte read after arrival
    send_frame(8'h00, 1'b1, -1, -1); check_outputs("b2b0"); pulse_read("b2b0");
    send_frame(8'hFF, 1'b1, -1, -1); check_outputs("b2b1"); pulse_read("b2b1");
    send_frame(8'h55, 1'b1, -1, -1); check_outputs("b2b2");
    send_frame(8'h80, 1'b1, DONE_C - 1, -1); check_outputs("b2b3");
    pulse_read("b2b3");
    idle_cycles(20, 1'b1);

    // glitch then valid frame
    idle_cycles(3, 1'b0);
    idle_cycles(30, 1'b1);
    check_outputs("glitch");
    send_frame(8'h3C, 1'b1, -1, -1);
    check_outputs("after_glitch");
    pulse_read("after_glitch");

    // framing error followed by a long break
    r0 = fe_rise;
    send_frame(8'h12, 1'b0, -1, -1);
    check_outputs("frame_err");
    idle_cycles(40 * P - P, 1'b0);
    check_outputs("break");
    check_val("fe_once", 32'(fe_rise - r0), 32'd1);
    idle_cycles(2 * P, 1'b1);
    send_frame(8'h34, 1'b1, -1, -1);
    check_outputs("after_break");
    pulse_read("after_break");

    // overrun, then simultaneous read at the stop sample
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    check_outputs("overrun");
    pulse_read("overrun");
    send_frame(8'h33, 1'b1, -1, -1);
    send_frame(8'h44, 1'b1, DONE_C - 1, -1);
    check_outputs("simul_read");
    pulse_read("simul_read");

    // reset during data bit 4
    send_frame(8'hC3, 1'b1, -1, 5 * P + 5);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    idle_cycles(20, 1'b1);
    send_frame(8'h7E, 1'b1, -1, -1);
    check_outputs("after_reset");
    pulse_read("after_reset");

    // randomized frames, read policies and gaps
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      mode = $urandom_range(0, 2);
      send_frame(b, st, (mode == 1) ? DONE_C - 1 : -1, -1);
      check_outputs($sformatf("rand%0d", i));
      if (mode == 2) pulse_read($sformatf("rand%0d", i));
      idle_cycles(st ? $urandom_range(0, 30) : 20 + $urandom_range(0, 30), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
